// File: rtl/cpu_state_dumper_pkg.sv
// rtl/cpu_state_dumper_pkg.sv - shared FSM encoding and dump geometry constants
package cpu_state_dumper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } dump_state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_NREG   = 8;
    localparam int DEF_NDM    = 8;
    localparam int DEF_CNT_W  = 16;

    // Word 0 of every dump is the cycle-stamp header.
    localparam int HDR_IDX = 0;

    // Width of the CPU freeze request.
    localparam int HOLD_W = 1;

    function automatic int dump_words(input int nreg, input int ndm);
        return 1 + nreg + ndm;
    endfunction

endpackage

// File: rtl/cpu_state_dumper_if.sv
// rtl/cpu_state_dumper_if.sv - valid/ready dump word stream
interface cpu_state_dumper_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 5
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic              last;

    modport master (output valid, data, idx, last, input ready);
    modport slave  (input valid, data, idx, last, output ready);
endinterface

// File: rtl/cpu_state_dumper_dbg_cycle_counter.sv
// rtl/cpu_state_dumper_dbg_cycle_counter.sv - free-running wrapping cycle counter with enable
module cpu_state_dumper_dbg_cycle_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_state_dumper.sv
// rtl/cpu_state_dumper.sv - freezes the CPU and streams a cycle-stamped register/memory dump
module cpu_state_dumper
    import cpu_state_dumper_pkg::*;
#(
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  NREG   = DEF_NREG,
    parameter int  NDM    = DEF_NDM,
    parameter int  CNT_W  = DEF_CNT_W,
    localparam int RA_W   = $clog2(NREG),
    localparam int DA_W   = $clog2(NDM),
    localparam int IDX_W  = $clog2(NREG + NDM + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              req,
    output logic [HOLD_W-1:0] hold,
    output logic              busy,
    output logic [RA_W-1:0]   reg_raddr,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic [DA_W-1:0]   dm_raddr,
    input  logic [DATA_W-1:0] dm_rdata,
    cpu_state_dumper_if.master dump
);

    localparam int LAST_IDX = dump_words(NREG, NDM) - 1;

    dump_state_t       state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  snap;
    logic              in_reg;
    logic              in_dm;

    cpu_state_dumper_dbg_cycle_counter #(.CNT_W(CNT_W)) u_cycle_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (run && (hold == '0)),
        .count (count)
    );

    // Read addresses are only meaningful during LOAD; parked at 0 otherwise.
    always_comb begin
        in_reg    = (idx >= IDX_W'(1)) && (idx <= IDX_W'(NREG));
        in_dm     = (idx > IDX_W'(NREG));
        reg_raddr = '0;
        dm_raddr  = '0;
        if (state == ST_LOAD && in_reg) begin
            reg_raddr = RA_W'(idx - IDX_W'(1));
        end
        if (state == ST_LOAD && in_dm) begin
            dm_raddr = DA_W'(idx - IDX_W'(NREG + 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            snap       <= '0;
            hold       <= '0;
            busy       <= 1'b0;
            dump.valid <= 1'b0;
            dump.data  <= '0;
            dump.idx   <= '0;
            dump.last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        state <= ST_LOAD;
                        idx   <= '0;
                        snap  <= count;
                        hold  <= '1;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    dump.valid <= 1'b1;
                    dump.idx   <= idx;
                    dump.last  <= (idx == IDX_W'(LAST_IDX));
                    if (idx == IDX_W'(HDR_IDX)) begin
                        dump.data <= DATA_W'(snap);
                    end else if (in_reg) begin
                        dump.data <= reg_rdata;
                    end else begin
                        dump.data <= dm_rdata;
                    end
                    state <= ST_SEND;
                end
                ST_SEND: begin
                    if (dump.ready) begin
                        dump.valid <= 1'b0;
                        if (dump.last) begin
                            dump.last <= 1'b0;
                            hold      <= '0;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_LOAD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
